// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: capture sequencer for the oscilloscope display path.
// Watches the ADC stream for a level-crossing trigger, writes a decimated record
// of SAMPLES samples into the display sample RAM, holds it until the VGA frame
// ends (or a rearm in single-shot mode), then re-arms. Also owns the vertical
// scale select, which changes only at frame boundaries.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   adc_data, adc_valid  14-bit unsigned ADC sample stream (mid-scale 8191)
//   trig_level           trigger threshold
//   trig_rising          1 = rising-edge trigger, 0 = falling-edge trigger
//   decim                store every (decim+1)-th valid sample
//   single               1 = single-shot, 0 = continuous
//   rearm                pulse; releases HOLD in single-shot mode after frame_done
//   frame_done           pulse at VGA end of frame
//   scale_up/scale_down  pulses adjusting the pending scale
//   shift                vertical scale to the ADC-to-VGA scaler
//   wr_en/wr_addr/wr_data  sample RAM write port (registered)
//   busy                 high in WAIT_TRIG and CAPTURE
//   triggered            one-cycle pulse when a trigger is accepted
//
// Build option: define AUTO_TRIG_EN to force a trigger after TIMEOUT valid
// samples in WAIT_TRIG without a level crossing.
module scope_capture_ctrl #(
  parameter int unsigned SAMPLES = 640,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [13:0]       adc_data,
  input  logic              adc_valid,
  input  logic [13:0]       trig_level,
  input  logic              trig_rising,
  input  logic [7:0]        decim,
  input  logic              single,
  input  logic              rearm,
  input  logic              frame_done,
  input  logic              scale_up,
  input  logic              scale_down,
  output logic [1:0]        shift,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [13:0]       wr_data,
  output logic              busy,
  output logic              triggered
);

  if ((64'd1 << ADDR_W) < 64'(SAMPLES) || TIMEOUT == 0) begin : gen_param_err
    $error("scope_capture_ctrl: need 2^ADDR_W >= SAMPLES and TIMEOUT > 0");
  end

  typedef enum logic [1:0] {StIdle, StWaitTrig, StCapture, StHold} state_e;

  state_e            state_q;
  logic [13:0]       prev_q;
  logic              prev_valid_q;
  logic [7:0]        decim_q;
  logic [7:0]        dcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              frame_seen_q;  // single-shot: frame_done seen while holding
  logic [1:0]        pend_q;

  logic level_hit;
  logic timeout_hit;
  logic trig_fire;

  always_comb begin
    level_hit = 1'b0;
    if (prev_valid_q) begin
      if (trig_rising) level_hit = (prev_q < trig_level) && (adc_data >= trig_level);
      else             level_hit = (prev_q > trig_level) && (adc_data <= trig_level);
    end
  end

`ifdef AUTO_TRIG_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT + 1);
  logic [TcntW-1:0] tcnt_q;
  assign timeout_hit = (tcnt_q == TcntW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  assign trig_fire = adc_valid && (level_hit || timeout_hit);

  // Pending scale moves freely; shift samples it only at frame boundaries, so a
  // pulse coincident with frame_done lands on the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 2'd0;
      shift  <= 2'd0;
    end else begin
      if (scale_up && !scale_down && pend_q != 2'd3)      pend_q <= pend_q + 2'd1;
      else if (scale_down && !scale_up && pend_q != 2'd0) pend_q <= pend_q - 2'd1;
      if (frame_done) shift <= pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      decim_q      <= '0;
      dcnt_q       <= '0;
      addr_q       <= '0;
      frame_seen_q <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      triggered    <= 1'b0;
`ifdef AUTO_TRIG_EN
      tcnt_q       <= '0;
`endif
    end else begin
      wr_en     <= 1'b0;
      triggered <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q      <= StWaitTrig;
          busy         <= 1'b1;
          prev_valid_q <= 1'b0;
`ifdef AUTO_TRIG_EN
          tcnt_q       <= '0;
`endif
        end
        StWaitTrig: begin
          if (adc_valid) begin
            prev_q       <= adc_data;
            prev_valid_q <= 1'b1;
            if (trig_fire) begin
              triggered <= 1'b1;
              decim_q   <= decim;
              dcnt_q    <= '0;
              wr_en     <= 1'b1;
              wr_addr   <= '0;
              wr_data   <= adc_data;
              addr_q    <= ADDR_W'(1);
              state_q   <= StCapture;
            end
`ifdef AUTO_TRIG_EN
            else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
`endif
          end
        end
        StCapture: begin
          if (adc_valid) begin
            if (dcnt_q == decim_q) begin
              dcnt_q  <= '0;
              wr_en   <= 1'b1;
              wr_addr <= addr_q;
              wr_data <= adc_data;
              addr_q  <= addr_q + 1'b1;
              if (addr_q == ADDR_W'(SAMPLES - 1)) begin
                state_q      <= StHold;
                busy         <= 1'b0;
                frame_seen_q <= 1'b0;
              end
            end else begin
              dcnt_q <= dcnt_q + 8'd1;
            end
          end
        end
        StHold: begin
          if (frame_done) frame_seen_q <= 1'b1;
          if ((!single && frame_done) || (single && rearm && frame_seen_q)) begin
            state_q      <= StWaitTrig;
            busy         <= 1'b1;
            prev_valid_q <= 1'b0;
`ifdef AUTO_TRIG_EN
            tcnt_q       <= '0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: inputs are driven on the falling edge,
// outputs are checked on the next falling edge (one cycle after the DUT samples).
module tb_scope_capture_ctrl;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [13:0]   adc_data;
  logic          adc_valid;
  logic [13:0]   trig_level;
  logic          trig_rising;
  logic [7:0]    decim;
  logic          single;
  logic          rearm;
  logic          frame_done;
  logic          scale_up;
  logic          scale_down;
  logic [1:0]    shift;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [13:0]   wr_data;
  logic          busy;
  logic          triggered;

  int checks   = 0;
  int failures = 0;

  scope_capture_ctrl #(
    .SAMPLES(640),
    .ADDR_W (AW),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_level (trig_level),
    .trig_rising(trig_rising),
    .decim      (decim),
    .single     (single),
    .rearm      (rearm),
    .frame_done (frame_done),
    .scale_up   (scale_up),
    .scale_down (scale_down),
    .shift      (shift),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: present a sample, let the DUT take it, land on the next falling
  // edge, then drop all one-cycle pulses.
  task automatic cyc(input logic v, input logic [13:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    @(negedge clk);
    adc_valid  = 1'b0;
    frame_done = 1'b0;
    rearm      = 1'b0;
    scale_up   = 1'b0;
    scale_down = 1'b0;
  endtask

  initial begin
    int nbad;
    int nwr;
    int k;
    int trig_at;

    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; trig_level = 14'd8191;
    trig_rising = 1'b1; decim = 8'd0; single = 1'b0; rearm = 1'b0;
    frame_done = 1'b0; scale_up = 1'b0; scale_down = 1'b0;
    @(negedge clk);
    cyc(1'b0, 14'd0);
    cyc(1'b0, 14'd0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shift", shift, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);

    // Rising trigger, decim=0, final write coincident with frame_done.
    rst = 1'b0;
    cyc(1'b0, 14'd0);
    chk("idle_to_wait_busy", busy, 1);
    cyc(1'b1, 14'd8000);
    chk("first_sample_no_trig", triggered, 0);
    cyc(1'b1, 14'd8100);
    chk("below_level_no_trig", triggered, 0);
    cyc(1'b1, 14'd8200);
    chk("rise_triggered", triggered, 1);
    chk("rise_wr_en", wr_en, 1);
    chk("rise_wr_addr0", wr_addr, 0);
    chk("rise_wr_data0", wr_data, 8200);
    nbad = 0;
    for (int i = 1; i < 640; i++) begin
      if (i == 639) frame_done = 1'b1;
      cyc(1'b1, 14'(8200 + i));
      if (!(wr_en === 1'b1 && wr_addr === AW'(i) && wr_data === 14'(8200 + i) &&
            triggered === 1'b0)) nbad++;
    end
    chk("rise_record_bad_writes", nbad, 0);
    chk("rise_hold_busy", busy, 0);
    cyc(1'b1, 14'd8000);
    chk("hold_no_write", wr_en, 0);
    chk("hold_not_released_by_final_frame", busy, 0);

    // Scale control.
    for (int i = 0; i < 5; i++) begin
      scale_up = 1'b1;
      cyc(1'b0, 14'd0);
    end
    chk("scale_unchanged_before_frame", shift, 0);
    frame_done = 1'b1;
    cyc(1'b0, 14'd0);
    chk("scale_saturate_up", shift, 3);
    chk("frame_releases_hold", busy, 1);
    scale_down = 1'b1; frame_done = 1'b1;
    cyc(1'b0, 14'd0);
    chk("scale_pulse_with_frame", shift, 3);
    scale_up = 1'b1; scale_down = 1'b1;
    cyc(1'b0, 14'd0);
    frame_done = 1'b1;
    cyc(1'b0, 14'd0);
    chk("scale_up_down_cancel", shift, 2);
    for (int i = 0; i < 3; i++) begin
      scale_down = 1'b1;
      cyc(1'b0, 14'd0);
    end
    frame_done = 1'b1;
    cyc(1'b0, 14'd0);
    chk("scale_saturate_down", shift, 0);

    // Falling trigger, decim=3 latched, valid every other cycle, single-shot.
    decim = 8'd3; trig_rising = 1'b0; single = 1'b1;
    cyc(1'b1, 14'd8400); cyc(1'b0, 14'd0);
    cyc(1'b1, 14'd8300); cyc(1'b0, 14'd0);
    chk("above_level_no_fall_trig", triggered, 0);
    cyc(1'b1, 14'd8100);
    chk("fall_triggered", triggered, 1);
    chk("fall_wr_addr0", wr_addr, 0);
    chk("fall_wr_data0", wr_data, 8100);
    decim = 8'd0;
    nbad = 0;
    nwr = 1;
    for (int j = 1; j <= 2556; j++) begin
      cyc(1'b0, 14'd0);
      if (wr_en !== 1'b0) nbad++;
      if (j == 100) rearm = 1'b1;
      cyc(1'b1, 14'(1000 + j));
      if (j % 4 == 0) begin
        if (!(wr_en === 1'b1 && wr_addr === AW'(j / 4) && wr_data === 14'(1000 + j))) nbad++;
      end else if (wr_en !== 1'b0) begin
        nbad++;
      end
      if (wr_en === 1'b1) nwr++;
    end
    chk("decim_bad_writes", nbad, 0);
    chk("decim_write_count", nwr, 640);
    chk("decim_hold_busy", busy, 0);
    frame_done = 1'b1;
    cyc(1'b0, 14'd0);
    chk("single_holds_after_frame", busy, 0);
    scale_up = 1'b1; cyc(1'b0, 14'd0);
    scale_up = 1'b1; cyc(1'b0, 14'd0);
    frame_done = 1'b1;
    cyc(1'b0, 14'd0);
    chk("single_holds_second_frame", busy, 0);
    chk("scale_two", shift, 2);
    rearm = 1'b1;
    cyc(1'b0, 14'd0);
    chk("rearm_releases", busy, 1);

    // Reset in the middle of a capture.
    decim = 8'd0; trig_rising = 1'b1; single = 1'b0;
    cyc(1'b1, 14'd8000);
    cyc(1'b1, 14'd8200);
    chk("pre_reset_trigger", triggered, 1);
    k = 0;
    while (wr_addr !== AW'(100) && k < 200) begin
      cyc(1'b1, 14'd8300);
      k++;
    end
    chk("reach_addr_100", wr_addr, 100);
    rst = 1'b1;
    cyc(1'b1, 14'd8300);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_shift", shift, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    cyc(1'b0, 14'd0);
    chk("post_rst_wait", busy, 1);
    cyc(1'b1, 14'd8000);
    cyc(1'b1, 14'd8200);
    chk("post_rst_retrigger", triggered, 1);
    chk("post_rst_wr_addr", wr_addr, 0);
    chk("post_rst_wr_data", wr_data, 8200);

    // Constant data below the level: only the timeout can trigger.
    rst = 1'b1;
    cyc(1'b0, 14'd0);
    rst = 1'b0;
    cyc(1'b0, 14'd0);
    trig_at = 0;
    k = 0;
    while (trig_at == 0 && k < 1000) begin
      k++;
      cyc(1'b1, 14'd100);
      if (triggered === 1'b1) trig_at = k;
    end
`ifdef AUTO_TRIG_EN
    chk("auto_trig_sample_index", trig_at, 17);
    nwr = (wr_en === 1'b1) ? 1 : 0;
    for (int i = 1; i < 640; i++) begin
      cyc(1'b1, 14'd100);
      if (wr_en === 1'b1) nwr++;
    end
    chk("auto_record_writes", nwr, 640);
    chk("auto_record_hold", busy, 0);
`else
    chk("no_auto_trigger", trig_at, 0);
    chk("still_waiting", busy, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
